// File: rtl/top_vec_checker_if.sv
// Vector ROM read port and float-core start/done handshake,
// bundled between the checker (master) and the ROM/core pair (slave).
interface top_vec_checker_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              vec_ce;
    logic [ADDR_W-1:0] vec_addr;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] z_q;
    logic              dut_start;
    logic              dut_ready;
    logic              dut_done;
    logic [DATA_W-1:0] dut_a;
    logic [DATA_W-1:0] dut_b;
    logic              dut_sign;
    logic [DATA_W-1:0] dut_result;

    modport master (
        output vec_ce, vec_addr,
        output dut_start, dut_a, dut_b, dut_sign,
        input  a_q, b_q, z_q,
        input  dut_ready, dut_done, dut_result
    );

    modport slave (
        input  vec_ce, vec_addr,
        input  dut_start, dut_a, dut_b, dut_sign,
        output a_q, b_q, z_q,
        output dut_ready, dut_done, dut_result
    );
endinterface

// File: rtl/top_vec_checker.sv
// Walks stored {a,b,z} vectors, runs the float core on sign-differing
// pairs and counts result mismatches; optional stop-on-first-error.
module top_vec_checker #(
    parameter int          DATA_W = 64,
    parameter int          DEPTH  = 22,
    parameter int          ADDR_W = 5,
    parameter int          CNT_W  = 5,
    parameter int          KEY_W  = 8,
    parameter logic [KEY_W-1:0] KEY_OK = 8'hA5
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic             stop_on_err,
    output logic             ap_done,
    output logic             ap_ready,
    output logic             ap_idle,
    output logic [CNT_W-1:0] ap_return,
    input  logic [KEY_W-1:0] working_key,
    top_vec_checker_if.master bus
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [6:0] {
        S_IDLE   = 7'b0000001,
        S_FETCH  = 7'b0000010,
        S_LOAD   = 7'b0000100,
        S_LAUNCH = 7'b0001000,
        S_WAIT   = 7'b0010000,
        S_SPUR   = 7'b0100000,
        S_CHECK  = 7'b1000000
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  err_cnt;
    logic              stop_q;
    logic              halt_q;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] z_r;
    logic [DATA_W-1:0] res_r;
    logic              sign_r;

    logic at_end;
    logic need;
    logic locked;
    logic mis;

    assign at_end = (idx == IDX_W'(DEPTH)) || halt_q;
    assign need   = bus.a_q[MSB] ^ bus.b_q[MSB];
    assign locked = (working_key != KEY_OK) && (idx[1:0] == 2'b01);
    assign mis    = (res_r != z_r);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= nxt;
    end

    always_comb begin
        nxt           = state;
        bus.vec_ce    = 1'b0;
        bus.dut_start = 1'b0;
        ap_done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ap_start) nxt = S_FETCH;
            end
            S_FETCH: begin
                if (at_end) begin
                    ap_done = 1'b1;
                    nxt     = S_IDLE;
                end else begin
                    bus.vec_ce = 1'b1;
                    nxt        = S_LOAD;
                end
            end
            S_LOAD: begin
                nxt = need ? S_LAUNCH : S_FETCH;
            end
            S_LAUNCH: begin
                bus.dut_start = 1'b1;
                if (bus.dut_ready) nxt = locked ? S_SPUR : S_WAIT;
            end
            S_WAIT, S_SPUR: begin
                if (bus.dut_done) nxt = S_CHECK;
            end
            S_CHECK: begin
                nxt = S_FETCH;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            idx     <= '0;
            err_cnt <= '0;
            stop_q  <= 1'b0;
            halt_q  <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            z_r     <= '0;
            res_r   <= '0;
            sign_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        idx     <= '0;
                        err_cnt <= '0;
                        stop_q  <= stop_on_err;
                        halt_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    a_r    <= bus.a_q;
                    b_r    <= bus.b_q;
                    z_r    <= bus.z_q;
                    sign_r <= bus.a_q[MSB];
                    if (!need) idx <= idx + IDX_W'(1);
                end
                S_WAIT: begin
                    if (bus.dut_done) res_r <= bus.dut_result;
                end
                S_SPUR: begin
                    // wrong key: the real result is swapped for idx+1
                    if (bus.dut_done) res_r <= DATA_W'(idx) + DATA_W'(1);
                end
                S_CHECK: begin
                    if (mis && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
                    if (mis && stop_q) halt_q <= 1'b1;
                    idx <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign ap_ready     = ap_done;
    assign ap_idle      = (state == S_IDLE) && !ap_start;
    assign ap_return    = err_cnt;
    assign bus.vec_addr = idx[ADDR_W-1:0];
    assign bus.dut_a    = a_r;
    assign bus.dut_b    = b_r;
    assign bus.dut_sign = sign_r;

endmodule

// File: tb/tb_top_vec_checker.sv
// Bench for top_vec_checker: ROM and float-core models plus a
// vector-level reference; a CNT_W=2 twin runs in lockstep.
module tb_top_vec_checker;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 22;
    localparam logic [7:0] KOK = 8'hA5;

    logic       ap_clk;
    logic       ap_rst_n;
    logic       ap_start;
    logic       stop_on_err;
    logic [7:0] working_key;
    logic       ap_done, ap_ready, ap_idle;
    logic [4:0] ap_return;
    logic       ap_done2, ap_ready2, ap_idle2;
    logic [1:0] ap_return2;

    int checks = 0;
    int errors = 0;
    int n_fetch = 0;
    int n_launch = 0;

    logic [DW-1:0] ra [DEPTH];
    logic [DW-1:0] rb [DEPTH];
    logic [DW-1:0] rz [DEPTH];

    top_vec_checker_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    top_vec_checker_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    top_vec_checker #(.CNT_W(5)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .ap_start(ap_start), .stop_on_err(stop_on_err),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .ap_return(ap_return), .working_key(working_key),
        .bus(bus1.master)
    );

    top_vec_checker #(.CNT_W(2)) dut2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .ap_start(ap_start), .stop_on_err(stop_on_err),
        .ap_done(ap_done2), .ap_ready(ap_ready2), .ap_idle(ap_idle2),
        .ap_return(ap_return2), .working_key(working_key),
        .bus(bus2.master)
    );

    assign bus2.a_q        = bus1.a_q;
    assign bus2.b_q        = bus1.b_q;
    assign bus2.z_q        = bus1.z_q;
    assign bus2.dut_ready  = bus1.dut_ready;
    assign bus2.dut_done   = bus1.dut_done;
    assign bus2.dut_result = bus1.dut_result;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) begin
        if (bus1.vec_ce) begin
            bus1.a_q <= ra[bus1.vec_addr];
            bus1.b_q <= rb[bus1.vec_addr];
            bus1.z_q <= rz[bus1.vec_addr];
        end
    end

    always @(posedge ap_clk) begin
        if (bus1.vec_ce) n_fetch <= n_fetch + 1;
        if (bus1.dut_start && bus1.dut_ready) n_launch <= n_launch + 1;
    end

    // float core stand-in: result is a+b, random ready and done delays
    initial begin
        int phase;
        int cnt;
        logic [DW-1:0] oa;
        logic [DW-1:0] ob;
        phase = 0;
        cnt = 0;
        oa = '0;
        ob = '0;
        bus1.dut_ready = 1'b0;
        bus1.dut_done = 1'b0;
        bus1.dut_result = '0;
        forever begin
            @(negedge ap_clk);
            bus1.dut_ready = 1'b0;
            bus1.dut_done = 1'b0;
            if (phase == 0 && bus1.dut_start) begin
                cnt = $urandom_range(0, 2);
                phase = 1;
            end
            if (phase == 1) begin
                if (cnt == 0) begin
                    bus1.dut_ready = 1'b1;
                    oa = bus1.dut_a;
                    ob = bus1.dut_b;
                    cnt = $urandom_range(1, 3);
                    phase = 2;
                end else begin
                    cnt = cnt - 1;
                end
            end else if (phase == 2) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    bus1.dut_done = 1'b1;
                    bus1.dut_result = oa + ob;
                    phase = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic gen(input logic [DEPTH-1:0] mask);
        for (int i = 0; i < DEPTH; i++) begin
            ra[i] = {$urandom, $urandom};
            rb[i] = {$urandom, $urandom};
            rb[i][DW-1] = ra[i][DW-1] ^ mask[i];
            rz[i] = ra[i] + rb[i];
        end
    endtask

    // Vector-level expectation: mismatches, fetches and launches
    function automatic int ref_mis(input bit stop, input logic [7:0] key,
                                   output int fetches, output int launches);
        int m;
        logic [DW-1:0] r;
        m = 0;
        fetches = 0;
        launches = 0;
        for (int i = 0; i < DEPTH; i++) begin
            fetches++;
            if (ra[i][DW-1] != rb[i][DW-1]) begin
                launches++;
                if (key != KOK && (i % 4) == 1) r = 64'(i + 1);
                else r = ra[i] + rb[i];
                if (r != rz[i]) begin
                    m++;
                    if (stop) break;
                end
            end
        end
        return m;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic run(input string tag, input bit stop,
                       input logic [7:0] key, output int cyc);
        int m, ef, el, f0, l0;
        m = ref_mis(stop, key, ef, el);
        @(negedge ap_clk);
        stop_on_err = stop;
        working_key = key;
        ap_start = 1'b1;
        f0 = n_fetch;
        l0 = n_launch;
        cyc = 0;
        do begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            cyc++;
        end while (!ap_done && cyc < 3000);
        chk({tag, " done"}, 64'(ap_done), 64'(1));
        chk({tag, " ready"}, 64'(ap_ready), 64'(1));
        chk({tag, " done2"}, 64'(ap_done2), 64'(1));
        chk({tag, " ret"}, 64'(ap_return), 64'(sat(m, 31)));
        chk({tag, " ret2"}, 64'(ap_return2), 64'(sat(m, 3)));
        chk({tag, " fetches"}, 64'(n_fetch - f0), 64'(ef));
        chk({tag, " launches"}, 64'(n_launch - l0), 64'(el));
        @(negedge ap_clk);
        chk({tag, " pulse"}, 64'(ap_done), 64'(0));
        chk({tag, " idle"}, 64'(ap_idle), 64'(1));
        chk({tag, " hold"}, 64'(ap_return), 64'(sat(m, 31)));
    endtask

    initial begin
        int cyc;
        bit found;
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        stop_on_err = 1'b0;
        working_key = KOK;
        gen('0);
        repeat (3) @(negedge ap_clk);
        chk("rst done", 64'(ap_done), 64'(0));
        chk("rst ready", 64'(ap_ready), 64'(0));
        chk("rst idle", 64'(ap_idle), 64'(1));
        chk("rst ret", 64'(ap_return), 64'(0));
        chk("rst vec_ce", 64'(bus1.vec_ce), 64'(0));
        chk("rst start", 64'(bus1.dut_start), 64'(0));
        chk("rst dut_a", bus1.dut_a, 64'(0));
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        gen(22'h055555);
        run("t1 clean", 1'b0, KOK, cyc);

        gen(22'h0AAAAA);
        rz[3] = rz[3] ^ 64'h1;
        rz[17] = rz[17] ^ 64'h8000;
        run("t2 two bad", 1'b0, KOK, cyc);
        run("t2 stop", 1'b1, KOK, cyc);

        gen(22'h000222);
        run("t3 spur", 1'b0, 8'h00, cyc);
        rz[5] = 64'd6;
        run("t3 spur hit", 1'b0, 8'h00, cyc);

        gen('0);
        run("t4 skip", 1'b0, KOK, cyc);
        chk("t4 cycles", 64'(cyc), 64'(2 * DEPTH + 1));

        gen(22'h0000FF);
        for (int i = 0; i < 5; i++) rz[i] = ~rz[i];
        run("t6 sat", 1'b0, KOK, cyc);

        gen(22'h3FFFFF);
        @(negedge ap_clk);
        stop_on_err = 1'b0;
        working_key = KOK;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge ap_clk);
            #1;
            if (bus1.dut_start && bus1.dut_ready && bus1.vec_addr == 5'd4)
                found = 1'b1;
        end
        chk("t5 reach idx4", 64'(found), 64'(1));
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("t5 start", 64'(bus1.dut_start), 64'(0));
        chk("t5 vec_ce", 64'(bus1.vec_ce), 64'(0));
        chk("t5 done", 64'(ap_done), 64'(0));
        chk("t5 ret", 64'(ap_return), 64'(0));
        chk("t5 dut_a", bus1.dut_a, 64'(0));
        chk("t5 sign", 64'(bus1.dut_sign), 64'(0));
        chk("t5 twin a", bus2.dut_a, 64'(0));
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (8) @(negedge ap_clk);
        chk("t5 late idle", 64'(ap_idle), 64'(1));
        chk("t5 late ret", 64'(ap_return), 64'(0));
        rz[4] = rz[4] ^ 64'h1;
        rz[10] = rz[10] ^ 64'h1;
        run("t5 rerun", 1'b0, KOK, cyc);

        for (int r = 0; r < 5; r++) begin
            logic [7:0] key;
            gen(22'($urandom));
            for (int i = 0; i < DEPTH; i++)
                if ($urandom_range(0, 3) == 0) rz[i] = rz[i] ^ 64'(1 << (i % 7));
            key = ($urandom_range(0, 1) == 1) ? KOK : 8'($urandom);
            run("rand", 1'($urandom_range(0, 1)), key, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
